// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered decode stage between fetch and the ALU.
// Turns an RV32I-style instruction into ALU control code, operand-select
// flags, register indices and a sign-extended immediate.
// Handshake: a transfer happens on a side only in a cycle where valid and
// ready are both high at the rising clock edge. valid never waits for ready,
// and a presented output bundle holds stable until it is taken.
// A 2-entry arrangement (output register + skid entry) keeps in_ready a
// pure register output: in_ready = !skid_full.
// Optional feature macro: ALU_CUSTOM_LOGIC_EN adds NOR/NAND on custom-0.
module alu_decode_stage #(
  parameter int          XLEN         = 32,
  parameter logic [3:0]  ILLEGAL_CTRL = 4'b0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic            use_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            is_branch,
  output logic            invert_zero,
  output logic            illegal
);

  typedef struct packed {
    logic [3:0]      alu_control;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            is_branch;
    logic            invert_zero;
    logic            illegal;
  } bundle_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_CUST0  = 7'b0001011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  // Shared funct3 -> ALU code map; alt selects SUB/SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_sh;
  bundle_t         dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  // Combinational decode of the incoming instruction into a bundle.
  always_comb begin
    dec     = '0;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    case (opcode)
      OPC_OP: dec.alu_control = alu_op(funct3, in_instr[30]);
      OPC_OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
          dec.illegal     = 1'b1;
          dec.alu_control = ILLEGAL_CTRL;
        end else begin
          dec.alu_control = alu_op(funct3, (funct3 == 3'b101) && in_instr[30]);
          dec.use_imm     = 1'b1;
          dec.imm         = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_sh : imm_i;
        end
      end
      OPC_LOAD: begin
        dec.alu_control = ALU_ADD;
        dec.use_imm     = 1'b1;
        dec.imm         = imm_i;
      end
      OPC_STORE: begin
        dec.alu_control = ALU_ADD;
        dec.use_imm     = 1'b1;
        dec.imm         = imm_s;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          dec.illegal     = 1'b1;
          dec.alu_control = ILLEGAL_CTRL;
        end else begin
          dec.is_branch   = 1'b1;
          dec.imm         = imm_b;
          // BNE/BLT/BLTU take the branch on a nonzero ALU result.
          dec.invert_zero = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
          case (funct3[2:1])
            2'b00:   dec.alu_control = ALU_SUB;
            2'b10:   dec.alu_control = ALU_SLT;
            default: dec.alu_control = ALU_SLTU;
          endcase
        end
      end
      OPC_LUI: begin
        dec.alu_control = ALU_ADD;
        dec.use_imm     = 1'b1;
        dec.imm         = imm_u;
        dec.rs1         = 5'd0;
      end
`ifdef ALU_CUSTOM_LOGIC_EN
      OPC_CUST0: begin
        if (funct3 == 3'b000) begin
          dec.alu_control = 4'b0100;
        end else if (funct3 == 3'b001) begin
          dec.alu_control = 4'b0101;
        end else begin
          dec.illegal     = 1'b1;
          dec.alu_control = ILLEGAL_CTRL;
        end
      end
`else
      OPC_CUST0: begin
        dec.illegal     = 1'b1;
        dec.alu_control = ILLEGAL_CTRL;
      end
`endif
      default: begin
        dec.illegal     = 1'b1;
        dec.alu_control = ILLEGAL_CTRL;
      end
    endcase
  end

  bundle_t out_q, skid_q;
  logic    out_valid_q, skid_full;
  logic    accept;

  assign accept = in_valid && in_ready;

  // Output register and skid entry; skid always drains first to keep FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_full   <= 1'b0;
      skid_q      <= '0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_full) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
        skid_full   <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= dec;
      skid_full <= 1'b1;
    end
  end

  assign in_ready    = !skid_full;
  assign out_valid   = out_valid_q;
  assign alu_control = out_q.alu_control;
  assign use_imm     = out_q.use_imm;
  assign imm         = out_q.imm;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;
  assign is_branch   = out_q.is_branch;
  assign invert_zero = out_q.invert_zero;
  assign illegal     = out_q.illegal;

endmodule
